// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - opcode, FSM state and depth definitions for the motion scheduler
package robot_pkg;

  localparam int SCHED_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_FRONT  = 2'b00,
    OP_TURN   = 2'b01,
    OP_REMOVE = 2'b10
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  // True when two or more request bits are set at once.
  function automatic logic multi_hot(input logic [2:0] c);
    return (c & (c - 3'd1)) != 3'd0;
  endfunction

endpackage

// File: rtl/robot_cmd_fifo.sv
// rtl/robot_cmd_fifo.sv - small FIFO holding pending actuator opcodes
module robot_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full queue refuses a push even if the head leaves in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/robot_motion_sched.sv
// rtl/robot_motion_sched.sv - budgeted robot command scheduler; ROBOT_SCHED_STATS_EN adds transfer counters
module robot_motion_sched
  import robot_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] budget,
  input  logic       cmd_front,
  input  logic       cmd_turn,
  input  logic       cmd_remove,
  output logic       stall,
  output logic       act_valid,
  output logic [1:0] act_op,
  input  logic       act_ack,
  output logic       trash_cleared,
  output logic [8:0] moves_left,
  output logic       mission_done,
  output logic       cmd_err
`ifdef ROBOT_SCHED_STATS_EN
  ,
  output logic [15:0] stat_front,
  output logic [15:0] stat_turn,
  output logic [15:0] stat_remove
`endif
);

  state_t     state;
  state_t     state_nx;
  logic [2:0] cmds;
  op_t        cmd_op;
  logic       accept;
  logic       load;
  logic       pop;
  logic [1:0] head;
  logic       empty;
  logic [2:0] count;
  logic [1:0] remove_run;

  assign cmds   = {cmd_remove, cmd_turn, cmd_front};
  assign load   = start && (state == IDLE || state == DONE);
  assign accept = (state == RUN) && (cmds != 3'd0) && !multi_hot(cmds)
                  && !stall && (moves_left != 9'd0);
  assign pop    = act_valid && act_ack;
  assign act_op = act_valid ? head : 2'b00;
  assign mission_done = (state == DONE);

  always_comb begin
    cmd_op = OP_FRONT;
    if (cmd_turn)   cmd_op = OP_TURN;
    if (cmd_remove) cmd_op = OP_REMOVE;
  end

  robot_cmd_fifo #(.DEPTH(SCHED_DEPTH), .WIDTH(2)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (accept),
    .wr_data (cmd_op),
    .pop     (pop),
    .rd_data (head),
    .full    (stall),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (budget == 9'd0) ? DRAIN : RUN;
      RUN:        if (moves_left == 9'd0) state_nx = DRAIN;
      DRAIN:      if (empty && !act_valid) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      moves_left    <= 9'd0;
      cmd_err       <= 1'b0;
      act_valid     <= 1'b0;
      trash_cleared <= 1'b0;
      remove_run    <= 2'd0;
    end else begin
      state         <= state_nx;
      trash_cleared <= 1'b0;
      if (load)        moves_left <= budget;
      else if (accept) moves_left <= moves_left - 9'd1;
      if (state == RUN && multi_hot(cmds)) cmd_err <= 1'b1;
      // Head is shown one cycle after it lands; later entries follow back-to-back.
      act_valid <= (count > 3'(pop));
      if (pop) begin
        if (head == OP_REMOVE) begin
          if (remove_run == 2'd2) begin
            remove_run    <= 2'd0;
            trash_cleared <= 1'b1;
          end else begin
            remove_run <= remove_run + 2'd1;
          end
        end else begin
          remove_run <= 2'd0;
        end
      end
    end
  end

`ifdef ROBOT_SCHED_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_front  <= 16'd0;
      stat_turn   <= 16'd0;
      stat_remove <= 16'd0;
    end else if (load) begin
      stat_front  <= 16'd0;
      stat_turn   <= 16'd0;
      stat_remove <= 16'd0;
    end else if (pop) begin
      if (head == OP_FRONT  && stat_front  != 16'hFFFF) stat_front  <= stat_front + 16'd1;
      if (head == OP_TURN   && stat_turn   != 16'hFFFF) stat_turn   <= stat_turn + 16'd1;
      if (head == OP_REMOVE && stat_remove != 16'hFFFF) stat_remove <= stat_remove + 16'd1;
    end
  end
`endif

endmodule
